// File: rtl/jt12_wr_pkg.sv
// Shared definitions for the jt12 CPU-port write sequencer and its FIFO.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package jt12_wr_pkg;

  // Status bit the chip raises while it cannot accept a write.
  localparam int BUSY_BIT = 7;

  // Command word width: {part, reg, val}.
  localparam int CMD_W = 17;

  // Sequencer states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POLL  = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_GAP_A = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_GAP_D = 3'd5;

  typedef struct packed {
    logic       part;
    logic [7:0] rg;
    logic [7:0] val;
  } cmd_t;

  // One counter serves both strobe width and busy timeout; it only ever
  // needs to hold values up to max(pulse, tout) - 1.
  function automatic int cnt_width(input int pulse, input int tout);
    int m;
    m = (pulse > tout) ? pulse : tout;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// Generic synchronous FIFO, power-of-two depth, extra pointer bit separates full from empty.
// Latency: a push is visible on dout/empty the cycle after it is written.
// Backpressure: push while full and pop while empty are ignored; push and pop together both act.
module jt12_wr_fifo #(
  parameter int FIFO_AW = 3,
  parameter int W       = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // Pointer advance; wrap comes from natural overflow of the extra bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers with synchronous reset (emptying the FIFO).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers guard them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/jt12_wr_seq.sv
// Queued register-write master for the jt12 CPU port: busy-poll, address strobe, data strobe.
// Latency: with cen=1 and chip not busy, 8 clocks per command from pop to idle (PULSE=2).
// Backpressure: cmd_ready drops when the command FIFO is full; offers are then ignored.
module jt12_wr_seq
  import jt12_wr_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int PULSE   = 2,
  parameter int TOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_part,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  input  logic [7:0] ym_dout,
  output logic [7:0] ym_din,
  output logic [1:0] ym_addr,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  output logic       idle,
  output logic       timeout_err,
  input  logic       clr_err
);

  localparam int CW = cnt_width(PULSE, TOUT);

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  cmd_t          fifo_cmd;
  logic [2:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          err_q, err_d;
  logic          tout_hit;
  logic          unused_dout;

  // Only the busy flag of the status byte matters here.
  assign unused_dout = ^ym_dout[BUSY_BIT-1:0];

  assign fifo_push   = cmd_valid && !fifo_full;
  assign cmd_ready   = !fifo_full;
  assign idle        = fifo_empty && (st_q == ST_IDLE);
  assign ym_din      = din_q;
  assign ym_addr     = addr_q;
  assign ym_cs_n     = cs_n_q;
  assign ym_wr_n     = wr_n_q;
  assign timeout_err = err_q;

  jt12_wr_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_part, cmd_reg, cmd_val}),
    .dout  (fifo_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state and next bus values; bus outputs are registered so every
  // field is computed for the state being entered.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    cs_n_d   = cs_n_q;
    wr_n_d   = wr_n_q;
    addr_d   = addr_q;
    din_d    = din_q;
    fifo_pop = 1'b0;
    tout_hit = 1'b0;
    if (cen) begin
      case (st_q)
        ST_IDLE: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cmd_d    = fifo_cmd;
            cnt_d    = '0;
            cs_n_d   = 1'b0;
            addr_d   = {fifo_cmd.part, 1'b0};
            st_d     = ST_POLL;
          end
        end
        ST_POLL: begin
          // A stuck busy flag must not wedge the queue: force the write.
          if (!ym_dout[BUSY_BIT] || (cnt_q == CW'(TOUT - 1))) begin
            tout_hit = ym_dout[BUSY_BIT];
            cnt_d    = '0;
            wr_n_d   = 1'b0;
            addr_d   = {cmd_q.part, 1'b0};
            din_d    = cmd_q.rg;
            st_d     = ST_ADDR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_ADDR, ST_DATA: begin
          if (cnt_q == CW'(PULSE - 1)) begin
            cnt_d  = '0;
            cs_n_d = 1'b1;
            wr_n_d = 1'b1;
            st_d   = (st_q == ST_ADDR) ? ST_GAP_A : ST_GAP_D;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GAP_A: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
          addr_d = {cmd_q.part, 1'b1};
          din_d  = cmd_q.val;
          st_d   = ST_DATA;
        end
        default: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          st_d   = ST_IDLE;
        end
      endcase
    end
    // A timeout landing on the same edge as a clear must stay visible.
    err_d = tout_hit ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  // State and bus registers; reset drops any in-flight strobe immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      cmd_q  <= '0;
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      cmd_q  <= cmd_d;
      cs_n_q <= cs_n_d;
      wr_n_q <= wr_n_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_jt12_wr_seq.sv
// Self-checking bench for jt12_wr_seq: directed timing plus randomized commands against a transaction model.
// Latency: not applicable.
// Backpressure: the bench honours cmd_ready when offering commands.
`timescale 1ns/1ps
module tb_jt12_wr_seq;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;
  localparam int PULSE   = 2;
  localparam int TOUT    = 8;

  logic       clk = 1'b0;
  logic       rst_n, cen, cmd_valid, cmd_ready, cmd_part;
  logic [7:0] cmd_reg, cmd_val, ym_dout, ym_din;
  logic [1:0] ym_addr;
  logic       ym_cs_n, ym_wr_n, idle, timeout_err, clr_err;

  always #5 clk = ~clk;

  jt12_wr_seq #(.FIFO_AW(FIFO_AW), .PULSE(PULSE), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
    .ym_dout(ym_dout), .ym_din(ym_din), .ym_addr(ym_addr),
    .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
    .idle(idle), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit throttle = 1'b0;
  bit err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observed write strobes on the chip bus.
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    int         w;
    int         gap;
    int         t;
    bit         ok;
  } strobe_t;

  strobe_t obs[$];
  strobe_t cur;
  int  hi_cnt = 0;
  int  ncyc = 0;
  bit  in_strobe = 1'b0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (ym_wr_n === 1'b0) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        cur.a = ym_addr; cur.d = ym_din; cur.w = 0;
        cur.gap = hi_cnt; cur.t = ncyc; cur.ok = 1'b1;
      end
      cur.w = cur.w + 1;
      if (ym_cs_n !== 1'b0 || ym_addr !== cur.a || ym_din !== cur.d) cur.ok = 1'b0;
    end else begin
      if (in_strobe) begin
        obs.push_back(cur);
        in_strobe = 1'b0;
        hi_cnt = 0;
      end
      hi_cnt = hi_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cen = throttle ? (cyc % 6 == 0) : 1'b1;
  endtask

  task automatic push(input logic [16:0] c);
    int g = 0;
    cmd_valid = 1'b1;
    {cmd_part, cmd_reg, cmd_val} = c;
    while (!cmd_ready && g < 200) begin tick(); g++; end
    if (!cmd_ready) chk("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    while (!idle && g < budget) begin tick(); g++; end
    chk("idle_reached", idle, 1);
  endtask

  // One command = address strobe to {part,0} with reg, then data strobe to {part,1} with val.
  task automatic check_cmd(input logic [16:0] c, input int per, output int t);
    strobe_t sa, sd;
    t = 0;
    if (obs.size() < 2) begin
      chk("strobe_count", obs.size(), 2);
      return;
    end
    sa = obs.pop_front();
    sd = obs.pop_front();
    t = sa.t;
    chk("addr_phase_addr", sa.a, {c[16], 1'b0});
    chk("addr_phase_din", sa.d, c[15:8]);
    chk("addr_phase_width", sa.w, PULSE * per);
    chk("addr_phase_stable", sa.ok, 1);
    chk("data_phase_addr", sd.a, {c[16], 1'b1});
    chk("data_phase_din", sd.d, c[7:0]);
    chk("data_phase_width", sd.w, PULSE * per);
    chk("data_phase_gap", sd.gap, per);
    chk("data_phase_stable", sd.ok, 1);
  endtask

  // Issue one command; the chip reports busy for the first k poll samples.
  task automatic run_cmd(input logic [16:0] c, input int k, input bit clr_hold, input int per);
    int polls = 0;
    int g = 0;
    int t;
    int dwell;
    bit exp_err;
    clr_err = clr_hold;
    ym_dout = 8'h00;
    push(c);
    while (ym_wr_n && g < 3000) begin
      if (!ym_cs_n) polls++;
      ym_dout = {(polls > 0 && polls <= k), 7'($urandom)};
      tick();
      g++;
    end
    exp_err = (k >= TOUT) || (err_m && !clr_hold);
    err_m = exp_err;
    dwell = ((k + 1 < TOUT) ? k + 1 : TOUT) * per;
    chk("poll_dwell", polls, dwell);
    chk("timeout_err", timeout_err, exp_err);
    clr_err = 1'b0;
    ym_dout = 8'h00;
    wait_idle(300);
    check_cmd(c, per, t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [16:0] c;
    logic [16:0] bq[$];
    int t, prev_t, occ, k;
    bit acc, ch, in_a, in_d;

    rst_n = 1'b0; cen = 1'b1; cmd_valid = 1'b0; cmd_part = 1'b0;
    cmd_reg = 8'h00; cmd_val = 8'h00; ym_dout = 8'h00; clr_err = 1'b0;
    tick(); tick();

    chk("rst_cs_n", ym_cs_n, 1);
    chk("rst_wr_n", ym_wr_n, 1);
    chk("rst_addr", ym_addr, 0);
    chk("rst_din", ym_din, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // Cycle-exact timeline of a single unbusy write, push at edge 0.
    c = {1'b0, 8'h28, 8'hF0};
    cmd_valid = 1'b1;
    {cmd_part, cmd_reg, cmd_val} = c;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      in_a = (e >= 2) && (e < 2 + PULSE);
      in_d = (e >= 3 + PULSE) && (e < 3 + 2 * PULSE);
      chk($sformatf("lat_wr_n_e%0d", e), ym_wr_n, !(in_a || in_d));
      chk($sformatf("lat_cs_n_e%0d", e), ym_cs_n, !(((e >= 1) && (e < 2 + PULSE)) || in_d));
      chk($sformatf("lat_idle_e%0d", e), idle, e >= 4 + 2 * PULSE);
      if (in_a) begin
        chk($sformatf("lat_addr_e%0d", e), ym_addr, 0);
        chk($sformatf("lat_din_e%0d", e), ym_din, 8'h28);
      end
      if (in_d) begin
        chk($sformatf("lat_addr_e%0d", e), ym_addr, 1);
        chk($sformatf("lat_din_e%0d", e), ym_din, 8'hF0);
      end
    end
    check_cmd(c, 1, t);

    // Part II with the chip busy for 5 samples.
    run_cmd({1'b1, 8'hA4, 8'h22}, 5, 1'b0, 1);

    // Stuck busy forces the write; clear; then set and clear on the same edge.
    run_cmd({1'b0, 8'h30, 8'h71}, 30, 1'b0, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0; err_m = 1'b0;
    chk("clr_err_clears", timeout_err, 0);
    run_cmd({1'b1, 8'h40, 8'h7F}, 30, 1'b1, 1);
    run_cmd({1'b0, 8'hB0, 8'h32}, 2, 1'b1, 1);

    // Back-to-back burst: strict order and fixed command period.
    bq.delete();
    for (int i = 0; i < 5; i++) begin
      c = 17'($urandom);
      bq.push_back(c);
      push(c);
    end
    wait_idle(300);
    chk("burst_count", obs.size(), 10);
    prev_t = 0;
    for (int i = 0; i < 5; i++) begin
      check_cmd(bq[i], 1, t);
      if (i > 0) chk("b2b_spacing", t - prev_t, 4 + 2 * PULSE);
      prev_t = t;
    end

    // FIFO full: FSM stalls on the first command, which has already been popped.
    ym_dout = 8'h80;
    occ = 0;
    bq.delete();
    for (int i = 0; i < 10; i++) begin
      c = 17'($urandom);
      cmd_valid = 1'b1;
      {cmd_part, cmd_reg, cmd_val} = c;
      acc = (occ < DEPTH);
      chk($sformatf("full_ready_%0d", i), cmd_ready, acc);
      if (acc) bq.push_back(c);
      tick();
      occ = occ + int'(acc) - ((i == 1) ? 1 : 0);
    end
    cmd_valid = 1'b0;
    ym_dout = 8'h00;
    err_m = 1'b1;
    wait_idle(400);
    chk("full_write_count", obs.size(), 2 * bq.size());
    while (bq.size() > 0) check_cmd(bq.pop_front(), 1, t);
    chk("full_err_set", timeout_err, err_m);
    clr_err = 1'b1; tick(); clr_err = 1'b0; err_m = 1'b0;
    chk("full_err_cleared", timeout_err, 0);

    // Random commands with random busy lengths and clear requests.
    for (int i = 0; i < 20; i++) begin
      c = 17'($urandom);
      k = $urandom_range(0, TOUT + 3);
      ch = 1'($urandom_range(0, 1));
      run_cmd(c, k, ch, 1);
    end

    // cen high one clock in six: every dwell scales by six.
    throttle = 1'b1;
    tick();
    run_cmd(17'($urandom), 0, 1'b0, 6);
    throttle = 1'b0;
    tick();

    // Reset during the data strobe with commands queued.
    ym_dout = 8'h00;
    for (int i = 0; i < 3; i++) push(17'($urandom));
    k = 0;
    while (!(ym_wr_n == 1'b0 && ym_addr[0] == 1'b1) && k < 200) begin tick(); k++; end
    chk("reached_data_strobe", ym_wr_n, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cs_n", ym_cs_n, 1);
    chk("mid_rst_wr_n", ym_wr_n, 1);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_ready", cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    obs.delete();
    repeat (40) tick();
    chk("no_writes_after_rst", obs.size(), 0);
    chk("idle_after_rst", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
